// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester (A = datapath, B = debug) arbiter in front of
// a 2-read/1-write register file. One transaction per two cycles: IDLE picks
// a winner and latches its fields, ISSUE drives the regfile strobes, and the
// read data is captured on the edge that ends ISSUE.
// Optional feature: define REGARB_RR_EN for round-robin on contention;
// the default build is fixed priority to A.

// Per-requester response holder: read results and the one-cycle valid pulse.
module regarb_rsp #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  output logic          rvalid,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [DW-1:0] rdata2_q, rdata2_d;

  // Capture regfile data when this requester's transaction ends, else hold.
  always_comb begin
    rvalid_d = cap;
    rdata1_d = cap ? d1 : rdata1_q;
    rdata2_d = cap ? d2 : rdata2_q;
  end

  // Response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;
endmodule

module regfile_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] raddr1_a,
  input  logic [AW-1:0] raddr2_a,
  input  logic [AW-1:0] waddr_a,
  input  logic [AW-1:0] raddr1_b,
  input  logic [AW-1:0] raddr2_b,
  input  logic [AW-1:0] waddr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata1_a,
  output logic [DW-1:0] rdata2_a,
  output logic [DW-1:0] rdata1_b,
  output logic [DW-1:0] rdata2_b,
  output logic          rf_we,
  output logic          rf_read1,
  output logic          rf_read2,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2
);
  localparam int NREQ = 2;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } txn_t;

  state_t state_q, state_d;
  txn_t   txn_q, txn_d;
  txn_t   txn_a, txn_b;
  logic   sel_q, sel_d;       // 0 = A owns the current transaction, 1 = B
  logic   gnt_a_q, gnt_a_d;
  logic   gnt_b_q, gnt_b_d;
  logic   any_req, pick_b;

  assign txn_a   = '{we: we_a, raddr1: raddr1_a, raddr2: raddr2_a, waddr: waddr_a, wdata: wdata_a};
  assign txn_b   = '{we: we_b, raddr1: raddr1_b, raddr2: raddr2_b, waddr: waddr_b, wdata: wdata_b};
  assign any_req = req_a | req_b;

`ifdef REGARB_RR_EN
  // ptr_q = 1 favours B. Only a contended grant moves it, to the loser, so a
  // lone requester never steals the next tie-break.
  logic ptr_q, ptr_d;

  // Winner selection and pointer update.
  always_comb begin
    pick_b = req_b & (~req_a | ptr_q);
    ptr_d  = ptr_q;
    if (state_q == IDLE && req_a && req_b) ptr_d = ~pick_b;
  end

  // Round-robin pointer, reset favouring A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
`else
  // Fixed priority: B wins only when A is not asking.
  always_comb begin
    pick_b = req_b & ~req_a;
  end
`endif

  // Next-state: IDLE -> ISSUE on any request; ISSUE always falls back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's fields and raise its grant for the ISSUE cycle.
  // Requests seen during ISSUE are ignored.
  always_comb begin
    txn_d   = txn_q;
    sel_d   = sel_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    if (state_q == IDLE && any_req) begin
      txn_d   = pick_b ? txn_b : txn_a;
      sel_d   = pick_b;
      gnt_a_d = ~pick_b;
      gnt_b_d = pick_b;
    end
  end

  // State, latched transaction and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      txn_q   <= '0;
      sel_q   <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      sel_q   <= sel_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
    end
  end

  // Regfile strobes: live only in ISSUE, so async reset silences them at once.
  // Writes to r0 are suppressed.
  always_comb begin
    rf_we     = 1'b0;
    rf_read1  = 1'b0;
    rf_read2  = 1'b0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    if (state_q == ISSUE) begin
      rf_we     = txn_q.we & (txn_q.waddr != '0);
      rf_read1  = 1'b1;
      rf_read2  = 1'b1;
      rf_raddr1 = txn_q.raddr1;
      rf_raddr2 = txn_q.raddr2;
      rf_waddr  = txn_q.waddr;
      rf_wdata  = txn_q.wdata;
    end
  end

  // Response capture: regfile read data is sampled on the same edge that
  // commits the write, which gives read-before-write.
  logic [NREQ-1:0]         cap;
  logic [NREQ-1:0]         rv;
  logic [NREQ-1:0][DW-1:0] rd1, rd2;

  assign cap[0] = (state_q == ISSUE) & ~sel_q;
  assign cap[1] = (state_q == ISSUE) &  sel_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    regarb_rsp #(.DW(DW)) u_rsp (
      .clk    (clk),
      .rst    (rst),
      .cap    (cap[i]),
      .d1     (rf_rdata1),
      .d2     (rf_rdata2),
      .rvalid (rv[i]),
      .rdata1 (rd1[i]),
      .rdata2 (rd2[i])
    );
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign rvalid_a = rv[0];
  assign rvalid_b = rv[1];
  assign rdata1_a = rd1[0];
  assign rdata2_a = rd2[0];
  assign rdata1_b = rd1[1];
  assign rdata2_b = rd2[1];
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 32x32 register file.
module tb_regfile_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk, rst;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] raddr1_a, raddr2_a, waddr_a, raddr1_b, raddr2_b, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
  logic          rf_we, rf_read1, rf_read2;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;

  int checks = 0;
  int errors = 0;

  regfile_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .raddr1_a(raddr1_a), .raddr2_a(raddr2_a), .waddr_a(waddr_a),
    .raddr1_b(raddr1_b), .raddr2_b(raddr2_b), .waddr_b(waddr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata1_a(rdata1_a), .rdata2_a(rdata2_a), .rdata1_b(rdata1_b), .rdata2_b(rdata2_b),
    .rf_we(rf_we), .rf_read1(rf_read1), .rf_read2(rf_read2),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write on rising edge.
  logic [DW-1:0] mem [32];
  initial for (int k = 0; k < 32; k++) mem[k] = '0;
  always @(posedge clk) if (rf_we) mem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = mem[rf_raddr1];
  assign rf_rdata2 = mem[rf_raddr2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input bit we, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] wa, input logic [31:0] wd);
    if (!b) begin
      req_a = 1'b1; we_a = we; raddr1_a = r1; raddr2_a = r2; waddr_a = wa; wdata_a = wd;
    end else begin
      req_b = 1'b1; we_b = we; raddr1_b = r1; raddr2_b = r2; waddr_b = wa; wdata_b = wd;
    end
  endtask

  // Lone-requester transaction, starting and ending at a negedge.
  task automatic txn(input string tag, input bit b, input bit we, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] wa, input logic [31:0] wd,
                     input bit exp_we, input logic [31:0] e1, input logic [31:0] e2);
    drive(b, we, r1, r2, wa, wd);
    @(posedge clk); @(negedge clk);
    chk({tag, ".gnt"}, b ? gnt_b : gnt_a, 1);
    chk({tag, ".gnt_other"}, b ? gnt_a : gnt_b, 0);
    chk({tag, ".rf_read1"}, rf_read1, 1);
    chk({tag, ".rf_raddr1"}, rf_raddr1, r1);
    chk({tag, ".rf_we"}, rf_we, exp_we);
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, ".rvalid"}, b ? rvalid_b : rvalid_a, 1);
    chk({tag, ".rdata1"}, b ? rdata1_b : rdata1_a, e1);
    chk({tag, ".rdata2"}, b ? rdata2_b : rdata2_a, e2);
    chk({tag, ".gnt_off"}, b ? gnt_b : gnt_a, 0);
    chk({tag, ".rf_idle"}, rf_read1, 0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".rvalid_pulse"}, b ? rvalid_b : rvalid_a, 0);
  endtask

  // Both request together: A reads r4 (ccffccff), B reads r13 (0000ffff).
  task automatic contend(input string tag, input bit first_b);
    drive(0, 0, 5'd4, 5'd0, 5'd0, 32'h0);
    drive(1, 0, 5'd13, 5'd0, 5'd0, 32'h0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".first_gnt_a"}, gnt_a, !first_b);
    chk({tag, ".first_gnt_b"}, gnt_b, first_b);
    if (first_b) req_b = 1'b0; else req_a = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, ".first_rvalid"}, first_b ? rvalid_b : rvalid_a, 1);
    chk({tag, ".first_rdata"}, first_b ? rdata1_b : rdata1_a,
        first_b ? 32'h0000ffff : 32'hccffccff);
    @(posedge clk); @(negedge clk);
    chk({tag, ".second_gnt_a"}, gnt_a, first_b);
    chk({tag, ".second_gnt_b"}, gnt_b, !first_b);
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, ".second_rvalid"}, first_b ? rvalid_a : rvalid_b, 1);
    chk({tag, ".rdata1_a"}, rdata1_a, 32'hccffccff);
    chk({tag, ".rdata1_b"}, rdata1_b, 32'h0000ffff);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    raddr1_a = 0; raddr2_a = 0; waddr_a = 0; wdata_a = 0;
    raddr1_b = 0; raddr2_b = 0; waddr_b = 0; wdata_b = 0;
    #2;
    chk("rst.gnt_a", gnt_a, 0);
    chk("rst.gnt_b", gnt_b, 0);
    chk("rst.rvalid_a", rvalid_a, 0);
    chk("rst.rdata1_a", rdata1_a, 0);
    chk("rst.rdata2_b", rdata2_b, 0);
    chk("rst.rf_we", rf_we, 0);
    chk("rst.rf_read1", rf_read1, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle.gnt_a", gnt_a, 0);
    chk("idle.rf_read2", rf_read2, 0);

    // write r4, then read it back with r31 (never written)
    txn("wr4", 0, 1, 5'd0, 5'd0, 5'd4, 32'hccffccff, 1, 32'h0, 32'h0);
    txn("rd4", 0, 0, 5'd4, 5'd31, 5'd0, 32'h0, 0, 32'hccffccff, 32'h0);
    // r0 is never written
    txn("wr0", 0, 1, 5'd0, 5'd0, 5'd0, 32'hffff0000, 0, 32'h0, 32'h0);
    txn("rd0", 0, 0, 5'd0, 5'd4, 5'd0, 32'h0, 0, 32'h0, 32'hccffccff);
    // B writes r13 while reading it: old value returned
    txn("wr13", 1, 1, 5'd13, 5'd4, 5'd13, 32'h0000ffff, 1, 32'h0, 32'hccffccff);
    chk("wr13.rdata2_a_hold", rdata2_a, 32'hccffccff);
    txn("rd13", 1, 0, 5'd13, 5'd0, 5'd0, 32'h0, 0, 32'h0000ffff, 32'h0);

`ifdef REGARB_RR_EN
    contend("tie1", 0);
    contend("tie2", 1);
`else
    contend("tie1", 0);
    contend("tie2", 0);
`endif

    // reset in the middle of a write ISSUE aborts it
    drive(0, 1, 5'd0, 5'd0, 5'd7, 32'hcccccccc);
    @(posedge clk); @(negedge clk);
    chk("abort.rf_we_pre", rf_we, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort.rf_we", rf_we, 0);
    chk("abort.gnt_a", gnt_a, 0);
    chk("abort.rdata1_a", rdata1_a, 0);
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.rvalid_a", rvalid_a, 0);
    @(negedge clk);
    chk("abort.rvalid_a2", rvalid_a, 0);
    txn("rd7", 0, 0, 5'd7, 5'd13, 5'd0, 32'h0, 0, 32'h0, 32'h0000ffff);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
